// File: rtl/i2c_slave_receiver.sv
// I2C write-only slave: syncs SCL/SDA, detects START/STOP,
// acks its own write address and streams received bytes out.
//
// Ports:
//   clock     system clock, all logic on rising edge
//   Reset     asynchronous active-low reset
//   SCL       I2C clock from the master (never stretched)
//   SDA       open-drain data: 0 while acking, else z
//   RxByte    last received data byte
//   RxValid   one-cycle pulse when RxByte updates
//   AddrMatch high from address ACK until STOP / repeated START
//   Busy      high from START until STOP
//   State     FSM state, for debug
module i2c_slave_receiver #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h3C,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       SCL,
    inout  wire        SDA,
    output logic [7:0] RxByte,
    output logic       RxValid,
    output logic       AddrMatch,
    output logic       Busy,
    output logic [2:0] State
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;

    logic [2:0] state;
    logic [3:0] bitcnt;
    logic [7:0] shift;
    logic       sda_oe;

    logic       start_ev;
    logic       stop_ev;
    logic       scl_rise;
    logic       scl_fall;
    logic [7:0] next_shift;

    // Only a pull-down is ever driven; async reset clears sda_oe at once.
    assign SDA = sda_oe ? 1'b0 : 1'bz;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // SCL must be high on both samples so an SDA change around an SCL
    // edge is never mistaken for START/STOP.
    assign start_ev = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_ev  = scl_s & scl_d & ~sda_d & sda_s;
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    assign next_shift = {shift[6:0], sda_s};

    // Synchronizers reset to 1 so the bus looks idle coming out of reset.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            bitcnt    <= 4'd0;
            shift     <= 8'h00;
            sda_oe    <= 1'b0;
            RxByte    <= 8'h00;
            RxValid   <= 1'b0;
            AddrMatch <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            RxValid <= 1'b0;
            if (stop_ev) begin
                state     <= IDLE;
                sda_oe    <= 1'b0;
                AddrMatch <= 1'b0;
                Busy      <= 1'b0;
                bitcnt    <= 4'd0;
            end else if (start_ev) begin
                state     <= ADDR;
                sda_oe    <= 1'b0;
                AddrMatch <= 1'b0;
                Busy      <= 1'b1;
                bitcnt    <= 4'd0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise && bitcnt < 4'd8) begin
                            shift  <= next_shift;
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt == 4'd7) begin
                                if (next_shift[7:1] == SLAVE_ADDR &&
                                    !next_shift[0])
                                    state <= ADDR_ACK;
                                else
                                    state <= IGNORE;
                            end
                        end
                    end
                    DATA: begin
                        if (scl_rise && bitcnt < 4'd8) begin
                            shift  <= next_shift;
                            bitcnt <= bitcnt + 4'd1;
                            if (bitcnt == 4'd7) begin
                                state   <= DATA_ACK;
                                RxByte  <= next_shift;
                                RxValid <= 1'b1;
                            end
                        end
                    end
                    // First fall after bit 8 starts the ACK, the next
                    // fall (end of clock 9) ends it; sda_oe tracks which.
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                                if (state == ADDR_ACK)
                                    AddrMatch <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                bitcnt <= 4'd0;
                                state  <= DATA;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign State = state;

endmodule

// File: tb/tb_i2c_slave_receiver.sv
// Bench for i2c_slave_receiver: bit-banged master, expected
// acks and byte stream computed from the addressing rules.
module tb_i2c_slave_receiver;

    localparam int         Q    = 6;
    localparam logic [6:0] ADDR = 7'h3C;

    logic       clock;
    logic       Reset;
    logic       scl;
    logic       m_low;
    wire        sda_bus;
    logic [7:0] rx;
    logic       rxv;
    logic       am;
    logic       busy;
    logic [2:0] st;

    int         checks;
    int         errors;
    logic [7:0] exp_q[$];
    logic [7:0] dbuf[4];

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    i2c_slave_receiver #(
        .SLAVE_ADDR (ADDR),
        .SYNC_STAGES(2)
    ) dut (
        .clock    (clock),
        .Reset    (Reset),
        .SCL      (scl),
        .SDA      (sda_bus),
        .RxByte   (rx),
        .RxValid  (rxv),
        .AddrMatch(am),
        .Busy     (busy),
        .State    (st)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (Reset && rxv) begin
            if (exp_q.size() == 0)
                chk("rxv_unexp", 32'(rxv), 32'd0);
            else
                chk("rxbyte", 32'(rx), 32'(exp_q.pop_front()));
        end
    end

    task automatic hq();
        repeat (Q) @(negedge clock);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; hq();
        scl   = 1'b1; hq();
        m_low = 1'b1; hq();
        scl   = 1'b0; hq();
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; hq();
        scl   = 1'b1; hq();
        m_low = 1'b0; hq();
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b; hq();
        scl   = 1'b1; hq(); hq();
        scl   = 1'b0; hq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_low = 1'b0; hq();
        scl   = 1'b1; hq();
        ack   = (sda_bus == 1'b0);
        hq();
        scl   = 1'b0; hq();
    endtask

    task automatic xfer(input logic [7:0] ab, input int nd);
        logic ack;
        logic m;
        m = (ab[7:1] == ADDR) && !ab[0];
        i2c_start();
        chk("busy_start", 32'(busy), 32'd1);
        chk("state_addr", 32'(st), 32'd1);
        send_byte(ab, ack);
        chk("addr_ack", 32'(ack), 32'(m));
        chk("state_post", 32'(st), m ? 32'd3 : 32'd5);
        chk("amatch", 32'(am), 32'(m));
        for (int i = 0; i < nd; i++) begin
            if (m) exp_q.push_back(dbuf[i]);
            send_byte(dbuf[i], ack);
            chk("data_ack", 32'(ack), 32'(m));
        end
        i2c_stop();
        chk("busy_stop", 32'(busy), 32'd0);
        chk("state_idle", 32'(st), 32'd0);
        chk("amatch_stop", 32'(am), 32'd0);
    endtask

    // Addressed transfer abandoned after n bits by a repeated START
    // (the START itself adds one more SCL rise, so n stays below 7).
    task automatic partial(input int n);
        logic ack;
        i2c_start();
        send_byte(8'h78, ack);
        chk("pre_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) send_bit(1'($urandom));
    endtask

    initial begin
        logic [7:0] ab;
        int         sel;
        checks = 0;
        errors = 0;
        Reset  = 1'b0;
        scl    = 1'b1;
        m_low  = 1'b0;
        #12 Reset = 1'b1;
        repeat (4) @(negedge clock);
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_sda", 32'(sda_bus), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rxbyte", 32'(rx), 32'd0);
        chk("rst_rxv", 32'(rxv), 32'd0);
        chk("rst_am", 32'(am), 32'd0);

        dbuf[0] = 8'hA5;
        xfer(8'h78, 1);
        xfer(8'h7A, 1);
        xfer(8'h79, 1);
        dbuf[0] = 8'h01;
        dbuf[1] = 8'hFF;
        xfer(8'h78, 2);
        partial(4);
        dbuf[0] = 8'h3C;
        xfer(8'h78, 1);

        // reset while the slave is holding SDA low for the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(ab_const(i));
        m_low = 1'b0; hq();
        scl   = 1'b1;
        repeat (2) @(negedge clock);
        chk("ack_low", 32'(sda_bus), 32'd0);
        Reset = 1'b0;
        #1;
        chk("mid_rst_sda", 32'(sda_bus), 32'd1);
        chk("mid_rst_state", 32'(st), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        hq();
        Reset = 1'b1;
        hq();
        dbuf[0] = 8'h5A;
        xfer(8'h78, 1);

        for (int t = 0; t < 16; t++) begin
            sel = int'($urandom_range(0, 3));
            ab  = (sel < 2) ? 8'h78 : (sel == 2) ? 8'($urandom) : 8'h79;
            for (int i = 0; i < 4; i++) dbuf[i] = 8'($urandom);
            if ($urandom_range(0, 3) == 0)
                partial(int'($urandom_range(1, 6)));
            xfer(ab, int'($urandom_range(0, 3)));
        end

        hq();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic ab_const(input int i);
        logic [7:0] a;
        a = 8'h78;
        return a[i];
    endfunction

endmodule
